// File: rtl/gradient_frame_sequencer.sv
// Front-end sequencer for the gradient pipeline: checks SOF/EOL geometry on the
// incoming AXI4-Stream, forwards pixels with a one-cycle latency and keeps frame/error statistics.
module gradient_frame_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMG_WIDTH  = 10,
    parameter int unsigned IMG_HEIGHT = 10
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] o_pixel,
    output logic                  o_pixel_valid,
    output logic                  o_start_of_frame,
    input  logic                  i_enable,
    input  logic                  i_single_shot,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_frame_abort,
    output logic                  o_err_eol,
    output logic                  o_err_sof,
    output logic [15:0]           o_frame_count,
    output logic [15:0]           o_err_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_ACTIVE,
        S_RESYNC
    } state_t;

    localparam logic [11:0] COL_LAST = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] ROW_LAST = 12'(IMG_HEIGHT - 1);

    state_t      state;
    logic [11:0] col;
    logic [11:0] row;
    logic        accept;
    logic        at_col_last;
    logic        at_row_last;
    logic        eol_bad;
    logic        sof_err;

    assign accept      = s_axis_tvalid & s_axis_tready;
    assign at_col_last = (col == COL_LAST);
    assign at_row_last = (row == ROW_LAST);
    // tlast must appear exactly on the last column of every line
    assign eol_bad     = s_axis_tlast ^ at_col_last;
    assign sof_err     = s_axis_tuser & ~((col == '0) & (row == '0));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state            <= S_IDLE;
            col              <= '0;
            row              <= '0;
            s_axis_tready    <= 1'b0;
            o_pixel          <= '0;
            o_pixel_valid    <= 1'b0;
            o_start_of_frame <= 1'b0;
            o_busy           <= 1'b0;
            o_frame_done     <= 1'b0;
            o_frame_abort    <= 1'b0;
            o_err_eol        <= 1'b0;
            o_err_sof        <= 1'b0;
            o_frame_count    <= '0;
            o_err_count      <= '0;
        end else begin
            s_axis_tready    <= 1'b1;
            o_pixel_valid    <= 1'b0;
            o_start_of_frame <= 1'b0;
            o_frame_done     <= 1'b0;
            o_frame_abort    <= 1'b0;
            o_err_eol        <= 1'b0;
            o_err_sof        <= 1'b0;
            if (accept) begin
                o_pixel <= s_axis_tdata;
            end

            unique case (state)
                S_IDLE: begin
                    if (i_enable) begin
                        state  <= S_WAIT_SOF;
                        o_busy <= 1'b1;
                    end
                end

                S_WAIT_SOF, S_RESYNC: begin
                    if (i_abort || !i_enable) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                        col    <= '0;
                        row    <= '0;
                    end else if (accept && s_axis_tuser) begin
                        o_pixel_valid    <= 1'b1;
                        o_start_of_frame <= 1'b1;
                        col              <= 12'd1;
                        row              <= '0;
                        state            <= S_ACTIVE;
                    end
                end

                S_ACTIVE: begin
                    if (i_abort) begin
                        state         <= S_IDLE;
                        o_busy        <= 1'b0;
                        o_frame_abort <= 1'b1;
                        col           <= '0;
                        row           <= '0;
                    end else if (accept) begin
                        o_pixel_valid <= 1'b1;
                        // a stray tuser restarts the frame; it outranks any EOL fault on the same beat
                        if (s_axis_tuser) begin
                            o_start_of_frame <= 1'b1;
                            col              <= 12'd1;
                            row              <= '0;
                            if (sof_err) begin
                                o_err_sof     <= 1'b1;
                                o_err_eol     <= eol_bad;
                                o_frame_abort <= 1'b1;
                                if (o_err_count != '1) o_err_count <= o_err_count + 16'd1;
                            end
                        end else if (eol_bad) begin
                            o_err_eol     <= 1'b1;
                            o_frame_abort <= 1'b1;
                            if (o_err_count != '1) o_err_count <= o_err_count + 16'd1;
                            col   <= '0;
                            row   <= '0;
                            state <= S_RESYNC;
                        end else if (at_col_last) begin
                            col <= '0;
                            if (at_row_last) begin
                                row           <= '0;
                                o_frame_done  <= 1'b1;
                                o_frame_count <= o_frame_count + 16'd1;
                                if (i_enable && !i_single_shot) begin
                                    state <= S_WAIT_SOF;
                                end else begin
                                    state  <= S_IDLE;
                                    o_busy <= 1'b0;
                                end
                            end else begin
                                row <= row + 12'd1;
                            end
                        end else begin
                            col <= col + 12'd1;
                        end
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gradient_frame_sequencer.sv
// Bench for gradient_frame_sequencer: a vector table, directed frame scenarios and a
// randomized run, all compared cycle by cycle against a linear-position frame model.
module tb_gradient_frame_sequencer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 32;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tuser;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] o_pixel;
    logic          o_pixel_valid;
    logic          o_start_of_frame;
    logic          i_enable;
    logic          i_single_shot;
    logic          i_abort;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_frame_abort;
    logic          o_err_eol;
    logic          o_err_sof;
    logic [15:0]   o_frame_count;
    logic [15:0]   o_err_count;

    always #5 i_clk = ~i_clk;

    gradient_frame_sequencer #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tready    (s_axis_tready),
        .o_pixel          (o_pixel),
        .o_pixel_valid    (o_pixel_valid),
        .o_start_of_frame (o_start_of_frame),
        .i_enable         (i_enable),
        .i_single_shot    (i_single_shot),
        .i_abort          (i_abort),
        .o_busy           (o_busy),
        .o_frame_done     (o_frame_done),
        .o_frame_abort    (o_frame_abort),
        .o_err_eol        (o_err_eol),
        .o_err_sof        (o_err_sof),
        .o_frame_count    (o_frame_count),
        .o_err_count      (o_err_count)
    );

    int checks = 0;
    int errors = 0;

    // Model: "busy" plus "inside a frame at linear position m_pos"
    bit            m_busy, m_inframe;
    int            m_pos;
    bit            e_tready, e_valid, e_sof, e_busy, e_done, e_fab, e_eeol, e_esof;
    logic [DW-1:0] e_pixel;
    logic [15:0]   e_fc, e_ec;

    int n_valid, n_sof, n_done, n_eeol, n_esof, n_fab;

    typedef struct {
        bit          rst, en, ss, ab, vld, usr, lst;
        logic [31:0] d;
        bit          x_tready, x_valid, x_sof, x_busy, x_eeol, x_esof, x_fab;
        logic [31:0] x_pix;
        logic [15:0] x_ec;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input bit rst, en, ss, ab, vld, usr, lst, input logic [31:0] d,
                                input bit t, v, s, b, ee, es, fa, input logic [31:0] px,
                                input logic [15:0] ec);
        vec_t r;
        r.rst = rst; r.en = en; r.ss = ss; r.ab = ab; r.vld = vld; r.usr = usr; r.lst = lst; r.d = d;
        r.x_tready = t; r.x_valid = v; r.x_sof = s; r.x_busy = b;
        r.x_eeol = ee; r.x_esof = es; r.x_fab = fa; r.x_pix = px; r.x_ec = ec;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic err_bump();
        if (e_ec != 16'hFFFF) e_ec++;
    endtask

    task automatic model_step(input bit rst, en, ss, ab, vld, usr, lst, input logic [DW-1:0] d);
        bit acc, bad;
        e_valid = 0; e_sof = 0; e_done = 0; e_fab = 0; e_eeol = 0; e_esof = 0;
        if (rst) begin
            m_busy = 0; m_inframe = 0; m_pos = 0; e_tready = 0; e_busy = 0;
            e_pixel = '0; e_fc = '0; e_ec = '0;
            return;
        end
        acc = vld && e_tready;
        e_tready = 1;
        if (acc) e_pixel = d;
        if (!m_busy) begin
            m_busy = en;
        end else if (ab) begin
            e_fab = m_inframe;
            m_busy = 0; m_inframe = 0; m_pos = 0;
        end else if (!m_inframe) begin
            if (!en) m_busy = 0;
            else if (acc && usr) begin
                e_valid = 1; e_sof = 1; m_inframe = 1; m_pos = 1;
            end
        end else if (acc) begin
            bad = lst != ((m_pos % W) == W - 1);
            e_valid = 1;
            if (usr) begin
                e_sof = 1;
                if (m_pos != 0) begin
                    e_esof = 1; e_fab = 1; e_eeol = bad; err_bump();
                end
                m_pos = 1;
            end else if (bad) begin
                e_eeol = 1; e_fab = 1; err_bump(); m_inframe = 0; m_pos = 0;
            end else if (m_pos == W * H - 1) begin
                e_done = 1; e_fc++; m_inframe = 0; m_pos = 0; m_busy = en && !ss;
            end else begin
                m_pos++;
            end
        end
        e_busy = m_busy;
    endtask

    task automatic check_model();
        chk("tready", s_axis_tready, e_tready);
        chk("pixel_valid", o_pixel_valid, e_valid);
        chk("pixel", o_pixel, e_pixel);
        chk("start_of_frame", o_start_of_frame, e_sof);
        chk("busy", o_busy, e_busy);
        chk("frame_done", o_frame_done, e_done);
        chk("frame_abort", o_frame_abort, e_fab);
        chk("err_eol", o_err_eol, e_eeol);
        chk("err_sof", o_err_sof, e_esof);
        chk("frame_count", o_frame_count, e_fc);
        chk("err_count", o_err_count, e_ec);
    endtask

    task automatic cycle(input bit rst, en, ss, ab, vld, usr, lst, input logic [DW-1:0] d);
        i_reset = rst; i_enable = en; i_single_shot = ss; i_abort = ab;
        s_axis_tvalid = vld; s_axis_tuser = usr; s_axis_tlast = lst; s_axis_tdata = d;
        @(posedge i_clk);
        model_step(rst, en, ss, ab, vld, usr, lst, d);
        #1;
        check_model();
        n_valid += int'(o_pixel_valid); n_sof += int'(o_start_of_frame);
        n_done += int'(o_frame_done);   n_eeol += int'(o_err_eol);
        n_esof += int'(o_err_sof);      n_fab += int'(o_frame_abort);
    endtask

    task automatic restart(input bit en, ss);
        cycle(1, 0, 0, 0, 0, 0, 0, '0);
        cycle(0, en, ss, 0, 0, 0, 0, '0);
        n_valid = 0; n_sof = 0; n_done = 0; n_eeol = 0; n_esof = 0; n_fab = 0;
    endtask

    task automatic beat(input int p, input bit en, ss);
        cycle(0, en, ss, 0, 1, p == 0, (p % W) == W - 1, 32'h100 + p);
    endtask

    task automatic send_frame(input bit en, ss);
        for (int p = 0; p < W * H; p++) beat(p, en, ss);
    endtask

    initial begin
        i_reset = 1; i_enable = 0; i_single_shot = 0; i_abort = 0;
        s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0; s_axis_tdata = '0;

        //            rst en ss ab vld usr lst d       t  v  s  b  ee es fa pix     ec
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h00,  0, 0, 0, 0, 0, 0, 0, 32'h00, 0);
        tbl[1]  = mk(0, 0, 0, 0, 1, 1, 0, 32'h11,  1, 0, 0, 0, 0, 0, 0, 32'h00, 0);
        tbl[2]  = mk(0, 1, 0, 0, 1, 1, 0, 32'h22,  1, 0, 0, 1, 0, 0, 0, 32'h22, 0);
        tbl[3]  = mk(0, 1, 0, 0, 1, 0, 0, 32'h33,  1, 0, 0, 1, 0, 0, 0, 32'h33, 0);
        tbl[4]  = mk(0, 1, 0, 0, 1, 1, 0, 32'h44,  1, 1, 1, 1, 0, 0, 0, 32'h44, 0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h55,  1, 0, 0, 1, 0, 0, 0, 32'h44, 0);
        tbl[6]  = mk(0, 1, 0, 0, 1, 0, 1, 32'h66,  1, 1, 0, 1, 1, 0, 1, 32'h66, 1);
        tbl[7]  = mk(0, 1, 0, 0, 1, 0, 0, 32'h77,  1, 0, 0, 1, 0, 0, 0, 32'h77, 1);
        tbl[8]  = mk(0, 1, 0, 0, 1, 1, 0, 32'h88,  1, 1, 1, 1, 0, 0, 0, 32'h88, 1);
        tbl[9]  = mk(0, 1, 0, 0, 1, 1, 1, 32'h99,  1, 1, 1, 1, 1, 1, 1, 32'h99, 2);
        tbl[10] = mk(0, 1, 0, 1, 1, 0, 0, 32'hAA,  1, 0, 0, 0, 0, 0, 1, 32'hAA, 2);
        tbl[11] = mk(0, 0, 0, 1, 0, 0, 0, 32'hBB,  1, 0, 0, 0, 0, 0, 0, 32'hAA, 2);

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].rst, tbl[i].en, tbl[i].ss, tbl[i].ab, tbl[i].vld, tbl[i].usr,
                  tbl[i].lst, tbl[i].d);
            chk($sformatf("vec%0d.tready", i), s_axis_tready, tbl[i].x_tready);
            chk($sformatf("vec%0d.valid", i), o_pixel_valid, tbl[i].x_valid);
            chk($sformatf("vec%0d.sof", i), o_start_of_frame, tbl[i].x_sof);
            chk($sformatf("vec%0d.busy", i), o_busy, tbl[i].x_busy);
            chk($sformatf("vec%0d.err_eol", i), o_err_eol, tbl[i].x_eeol);
            chk($sformatf("vec%0d.err_sof", i), o_err_sof, tbl[i].x_esof);
            chk($sformatf("vec%0d.frame_abort", i), o_frame_abort, tbl[i].x_fab);
            chk($sformatf("vec%0d.pixel", i), o_pixel, tbl[i].x_pix);
            chk($sformatf("vec%0d.err_count", i), o_err_count, tbl[i].x_ec);
        end

        // Two clean back-to-back frames in continuous mode
        restart(1, 0);
        send_frame(1, 0);
        send_frame(1, 0);
        chk("s1.valid_pulses", n_valid, 24);
        chk("s1.sof_pulses", n_sof, 2);
        chk("s1.done_pulses", n_done, 2);
        chk("s1.frame_count", o_frame_count, 2);
        chk("s1.err_count", o_err_count, 0);

        // Leading beats without tuser are dropped
        restart(1, 0);
        for (int k = 0; k < 5; k++) cycle(0, 1, 0, 0, 1, 0, k == 3, 32'h200 + k);
        send_frame(1, 0);
        chk("s2.valid_pulses", n_valid, 12);
        chk("s2.frame_count", o_frame_count, 1);

        // Early tlast on row 1 col 2, rest of frame dropped, then a clean frame
        restart(1, 0);
        for (int p = 0; p < W * H; p++)
            cycle(0, 1, 0, 0, 1, p == 0, ((p % W) == W - 1) || p == 6, 32'h300 + p);
        send_frame(1, 0);
        chk("s3.valid_pulses", n_valid, 19);
        chk("s3.eol_pulses", n_eeol, 1);
        chk("s3.abort_pulses", n_fab, 1);
        chk("s3.done_pulses", n_done, 1);
        chk("s3.err_count", o_err_count, 1);
        chk("s3.frame_count", o_frame_count, 1);

        // Stray tuser at row 1 col 2 restarts the frame
        restart(1, 0);
        for (int p = 0; p < 6; p++) beat(p, 1, 0);
        cycle(0, 1, 0, 0, 1, 1, 0, 32'h3C3);
        chk("s4.sof_on_stray", o_start_of_frame, 1);
        for (int p = 1; p < W * H; p++) beat(p, 1, 0);
        chk("s4.err_sof_pulses", n_esof, 1);
        chk("s4.valid_pulses", n_valid, 18);
        chk("s4.frame_count", o_frame_count, 1);
        chk("s4.err_count", o_err_count, 1);

        // Single shot: only the first of two back-to-back frames is forwarded
        restart(1, 1);
        send_frame(1, 1);
        chk("s5.busy_after_first", o_busy, 0);
        send_frame(1, 1);
        cycle(0, 0, 1, 0, 0, 0, 0, '0);
        chk("s5.valid_pulses", n_valid, 12);
        chk("s5.frame_count", o_frame_count, 1);
        chk("s5.busy_final", o_busy, 0);

        // Abort on beat 6
        restart(1, 0);
        for (int p = 0; p < 6; p++) beat(p, 1, 0);
        cycle(0, 1, 0, 1, 1, 0, 0, 32'h606);
        chk("s6.abort_pulse", o_frame_abort, 1);
        chk("s6.abort_no_valid", o_pixel_valid, 0);
        chk("s6.abort_busy", o_busy, 0);
        for (int p = 7; p < W * H; p++) beat(p, 1, 0);
        chk("s6.valid_pulses", n_valid, 6);
        chk("s6.frame_count", o_frame_count, 0);

        // Reset mid-frame
        restart(1, 0);
        for (int p = 0; p < 5; p++) beat(p, 1, 0);
        cycle(1, 1, 0, 0, 1, 0, 0, 32'h777);
        cycle(1, 1, 0, 0, 1, 0, 0, 32'h778);
        chk("s7.rst_tready", s_axis_tready, 0);
        chk("s7.rst_valid", o_pixel_valid, 0);
        chk("s7.rst_pixel", o_pixel, 0);
        chk("s7.rst_busy", o_busy, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, '0);
        chk("s7.post_tready", s_axis_tready, 1);
        chk("s7.post_busy", o_busy, 0);

        // Randomized mostly-well-formed traffic
        begin
            int  gpos;
            bit  en, ss, ab, rst, vld, usr, lst;
            gpos = 0; en = 1; ss = 0;
            for (int c = 0; c < 4000; c++) begin
                if ($urandom_range(0, 149) == 0) en = ~en;
                if ($urandom_range(0, 199) == 0) ss = ~ss;
                ab  = ($urandom_range(0, 149) == 0);
                rst = ($urandom_range(0, 799) == 0);
                vld = ($urandom_range(0, 9) < 8);
                usr = (gpos == 0);
                lst = ((gpos % W) == W - 1);
                if ($urandom_range(0, 39) == 0) usr = ~usr;
                if ($urandom_range(0, 39) == 0) lst = ~lst;
                cycle(rst, en, ss, ab, vld, usr, lst, $urandom);
                if (vld) gpos = (gpos + 1) % (W * H);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gradient_frame_sequencer.md
Name: gradient_frame_sequencer

Overview:
- Sits between the incoming video AXI4-Stream slave and the kernel/gradient pipeline that feeds the M_AXIS output stage.
- Validates frame geometry (SOF/EOL) against IMG_WIDTH x IMG_HEIGHT and generates the pipeline's pixel/valid/start-of-frame strobes.
- Gates frames on software enable, single-shot or continuous mode, and abort.
- Counts completed frames and geometry errors, and resynchronises to the next tuser after a malformed frame.

Parameters:
- DATA_WIDTH, 32, pixel width.
- IMG_WIDTH, 10, pixels per line (2..4095).
- IMG_HEIGHT, 10, lines per frame (2..4095).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous reset, active-high.
- s_axis_tdata  in  DATA_WIDTH  input pixel.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tuser  in  1  start of frame (first beat).
- s_axis_tlast  in  1  end of line.
- s_axis_tready  out  1  input ready.
- o_pixel  out  DATA_WIDTH  pixel to pipeline.
- o_pixel_valid  out  1  pixel strobe to pipeline.
- o_start_of_frame  out  1  asserted with the first forwarded pixel of a frame.
- i_enable  in  1  level; run frames while high.
- i_single_shot  in  1  level; when high, return to IDLE after one frame.
- i_abort  in  1  pulse; stop immediately.
- o_busy  out  1  high in WAIT_SOF, ACTIVE, RESYNC.
- o_frame_done  out  1  1-cycle pulse per good frame.
- o_frame_abort  out  1  1-cycle pulse when a forwarded frame is cut short.
- o_err_eol  out  1  1-cycle pulse on early or missing tlast.
- o_err_sof  out  1  1-cycle pulse on tuser seen mid-frame.
- o_frame_count  out  16  good frames, wraps.
- o_err_count  out  16  errors, saturates at 16'hFFFF.

Behaviour:
- **Reset:** all outputs 0, state IDLE, column/row counters 0. Reset wins over every other input.
- **Ready:** s_axis_tready is a register, 0 in reset, 1 in every state thereafter. The pipeline has no backpressure, so input beats are never stalled.
- **Accept:** a beat is accepted when tvalid & tready.
- **Forwarding latency:** 1 cycle.
  - o_pixel <= tdata on every accepted beat; otherwise o_pixel holds.
  - o_pixel_valid <= (beat accepted and forwarded); otherwise 0.
- **Counters:** col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1, 12 bits each, updated only on forwarded beats.
- **IDLE:** accepted beats are discarded. i_enable=1 -> WAIT_SOF.
- **WAIT_SOF:**
  - Beats without tuser are discarded.
  - A beat with tuser is forwarded with o_start_of_frame=1; col=1, row=0 (or col=0, row=1 if IMG_WIDTH=1 is excluded by range) -> ACTIVE.
  - i_enable=0 -> IDLE.
- **ACTIVE, each forwarded beat:**
  - col<IMG_WIDTH-1 and tlast=1: early EOL. Beat is forwarded; o_err_eol, o_frame_abort; err_count++ -> RESYNC.
  - col==IMG_WIDTH-1 and tlast=0: missing EOL. Beat is forwarded; same error handling -> RESYNC.
  - col==IMG_WIDTH-1 and tlast=1: col=0, row++.
  - On the last beat (row IMG_HEIGHT-1, col IMG_WIDTH-1, tlast=1): o_frame_done next cycle; frame_count++; counters cleared.
    - If i_enable & ~i_single_shot -> WAIT_SOF, else -> IDLE.
  - tuser on a beat that is not col0/row0: o_err_sof, o_frame_abort, err_count++. The beat is treated as a new SOF: forwarded with o_start_of_frame=1, col=1, row=0, stay ACTIVE.
- **RESYNC:** discard beats until tuser. The tuser beat is handled exactly as in WAIT_SOF -> ACTIVE. i_enable=0 -> IDLE.
- **Enable:** i_enable falling mid-frame does not stop the current frame; it is checked only at frame end and in WAIT_SOF/RESYNC.
- **Abort:** i_abort in any non-IDLE state -> IDLE next cycle; the current beat is not forwarded; counters cleared.
  - o_frame_abort pulses only if state was ACTIVE.
  - i_abort takes priority over a simultaneous frame end: no o_frame_done, no frame_count increment.
- **Simultaneous errors:** early-EOL and tuser on the same beat: the SOF rule wins, err_count increments by 1, and both o_err_sof and o_err_eol pulse.
- **o_busy:** registered from nextstate, so it has the same timing as the data outputs.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3):
1. Reset, then i_enable=1, i_single_shot=0; send 2 clean 12-beat frames with tlast on col 3 and tuser on beat 0 -> 24 o_pixel_valid pulses, each 1 cycle after input; o_start_of_frame on pixels 0 and 12; o_frame_done twice; frame_count=2; err_count=0.
2. Send 5 beats without tuser, then a clean frame -> first 5 beats are not forwarded; frame forwarded normally; frame_count=1.
3. Send tlast on col 2 of row 1 -> that beat is forwarded, then o_err_eol and o_frame_abort pulse; the rest of the frame is dropped; the next clean frame gives o_frame_done; err_count=1, frame_count=1.
4. Send tuser at row 1 col 2 -> o_err_sof pulses; o_start_of_frame is on that beat; the following 11 clean beats complete a frame; frame_count=1.
5. Set i_single_shot=1 and send 2 frames back-to-back -> only the first is forwarded; state is IDLE and o_busy=0 afterwards.
6. Assert i_abort at beat 6 of a frame, and separately assert i_reset mid-frame -> abort: no further o_pixel_valid, o_frame_abort pulses. Reset: all outputs 0 and s_axis_tready=0 during reset, then tready=1 and state IDLE.
